// File: rtl/reg_mem_pkg.sv
// Shared defaults and word/address types for the reg_mem register-file memory.
package reg_mem_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_BITS  = 5;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;
  typedef logic [DEFAULT_ADDR_BITS-1:0]  addr_t;

endpackage

// File: rtl/reg_mem.sv
// Flop-based single-port register file: synchronous write, registered read on a
// shared address bus. Reset clears every word and the read register.
module reg_mem
  import reg_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_BITS  = DEFAULT_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("reg_mem: DATA_WIDTH must be >= 1");
  end
  if (ADDR_BITS < 1) begin : g_bad_addr
    $error("reg_mem: ADDR_BITS must be >= 1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;

  // A write cycle leaves data_out untouched, so there is no write-through.
  always_comb begin
    mem_d      = mem_q;
    data_out_d = data_out_q;
    if (wen) begin
      mem_d[addr] = data_in;
    end else begin
      data_out_d = mem_q[addr];
    end
  end

  // Reset wins over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      data_out_q <= '0;
    end else begin
      mem_q      <= mem_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_reg_mem.sv
// Directed bench for reg_mem: reset, wrapped fill, latency, overwrite,
// mid-run reset and boundary addresses against hand-computed values.
module tb_reg_mem;
  import reg_mem_pkg::*;

  logic  clk;
  logic  rst;
  addr_t addr;
  word_t data_in;
  logic  wen;
  word_t data_out;

  int n_vec;
  int n_bad;

  reg_mem #(
    .DATA_WIDTH(8),
    .ADDR_BITS (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .data_in (data_in),
    .wen     (wen),
    .data_out(data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_write(input addr_t a, input word_t d);
    @(negedge clk);
    rst     = 1'b0;
    wen     = 1'b1;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input addr_t a, input word_t exp, input string tag);
    @(negedge clk);
    rst  = 1'b0;
    wen  = 1'b0;
    addr = a;
    @(posedge clk);
    #1;
    check(tag, data_out, exp);
  endtask

  initial begin
    word_t held;
    n_vec   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    wen     = 1'b0;
    addr    = '0;
    data_in = '0;

    // Reset held for two clocks.
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", data_out, 8'h00);
    for (int i = 0; i < 32; i++) begin
      do_read(addr_t'(i), 8'h00, $sformatf("reset_rd[%0d]", i));
    end

    // Fill with wrapped addresses: addr (i+2) mod 32 gets value i.
    for (int i = 1; i < 32; i++) begin
      do_write(addr_t'((i + 2) % 32), word_t'(i));
    end
    for (int i = 1; i < 32; i++) begin
      do_read(addr_t'((i + 2) % 32), word_t'(i), $sformatf("fill_rd[%0d]", (i + 2) % 32));
    end
    do_read(5'd0, 8'd30, "fill_wrap0");
    do_read(5'd1, 8'd31, "fill_wrap1");
    do_read(5'd2, 8'd00, "fill_untouched2");

    // Write then read latency; data_out must hold across the write.
    held = data_out;
    do_write(5'd7, 8'hA5);
    check("write_hold", data_out, held);
    @(negedge clk);
    wen  = 1'b0;
    addr = 5'd7;
    #1;
    check("no_comb_path", data_out, held);
    @(posedge clk);
    #1;
    check("read_lat1", data_out, 8'hA5);

    // Overwrite and neighbours.
    do_write(5'd4, 8'h11);
    do_write(5'd4, 8'h22);
    do_read(5'd4, 8'h22, "overwrite4");
    do_read(5'd3, 8'h01, "neigh3");
    do_read(5'd5, 8'h03, "neigh5");

    // Reset with a write pending: write must be discarded.
    @(negedge clk);
    rst     = 1'b1;
    wen     = 1'b1;
    addr    = 5'd9;
    data_in = 8'hFF;
    @(posedge clk);
    #1;
    check("midrst_dout", data_out, 8'h00);
    do_read(5'd9, 8'h00, "midrst_rd9");
    for (int i = 0; i < 32; i++) begin
      do_read(addr_t'(i), 8'h00, $sformatf("midrst_rd[%0d]", i));
    end

    // Boundary addresses.
    do_write(5'd0, 8'h80);
    do_write(5'd31, 8'h7F);
    do_read(5'd0, 8'h80, "bound0");
    do_read(5'd31, 8'h7F, "bound31");
    do_read(5'd1, 8'h00, "bound1_clear");
    do_read(5'd30, 8'h00, "bound30_clear");
    do_read(5'd0, 8'h80, "bound0_again");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
